// File: rtl/col_drain_arbiter.sv
// col_drain_arbiter: round-robin drain of COLS column controllers, ROWS words
// each, onto one registered valid/ready port. Optional tags: SYSTOLA_DRAIN_TAG_EN.
module col_drain_arbiter #(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int OUTWIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    input  logic [COLS-1:0]                    col_rvalid,
    input  logic [COLS-1:0][OUTWIDTH-1:0]      col_r,
    output logic [COLS-1:0]                    col_read,
    output logic [OUTWIDTH-1:0]                out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic                               busy,
`ifdef SYSTOLA_DRAIN_TAG_EN
    output logic [$clog2(COLS)-1:0]            out_col,
    output logic [$clog2(ROWS)-1:0]            out_row,
`endif
    output logic                               done
);

    localparam int GW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WW = $clog2(ROWS + 1);

    localparam logic [GW-1:0] GMAX  = GW'(COLS - 1);
    localparam logic [WW-1:0] WLAST = WW'(ROWS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARB   = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]       g_q, g_d;
    logic [WW-1:0]       wc_q, wc_d;
    logic [COLS-1:0]     served_q, served_d;
    logic [OUTWIDTH-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
`ifdef SYSTOLA_DRAIN_TAG_EN
    logic [GW-1:0]       out_col_q, out_col_d;
    logic [RW-1:0]       out_row_q, out_row_d;
`endif

    logic                arb_found;
    logic [GW-1:0]       arb_g;
    logic [GW-1:0]       arb_cand;
    logic                load;
    logic                accept;
    logic                last_row;
    logic [COLS-1:0]     served_after;

    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base,
                                             input int off);
        int s;
        s = int'(base) + off;
        if (s >= COLS) s = s - COLS;
        return GW'(s);
    endfunction

    // Round-robin search: first valid, unserved column at or after ptr.
    always_comb begin
        arb_found = 1'b0;
        arb_g     = '0;
        arb_cand  = '0;
        for (int i = 0; i < COLS; i++) begin
            arb_cand = rr_idx(ptr_q, i);
            if (!arb_found && col_rvalid[arb_cand] && !served_q[arb_cand]) begin
                arb_found = 1'b1;
                arb_g     = arb_cand;
            end
        end
    end

    assign accept       = out_valid_q && out_ready;
    assign load         = (state_q == BURST) && col_rvalid[g_q]
                          && (!out_valid_q || out_ready) && !abort;
    assign last_row     = (wc_q == WLAST);
    assign served_after = served_q | (COLS'(1) << g_q);

    // One-hot pop strobe follows the load decision in the same cycle.
    always_comb begin
        col_read = '0;
        if (load) col_read[g_q] = 1'b1;
    end

    // Next-state for the FSM, output register and drain bookkeeping.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        g_d         = g_q;
        wc_d        = wc_q;
        served_d    = served_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef SYSTOLA_DRAIN_TAG_EN
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
`endif
        if (load) begin
            out_data_d  = col_r[g_q];
            out_valid_d = 1'b1;
            out_last_d  = last_row && (&served_after);
`ifdef SYSTOLA_DRAIN_TAG_EN
            out_col_d   = g_q;
            out_row_d   = wc_q[RW-1:0];
`endif
        end else if (accept) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    served_d = '0;
                    ptr_d    = '0;
                    state_d  = ARB;
                end
            end
            ARB: begin
                if (&served_q) begin
                    state_d = FLUSH;
                end else if (arb_found) begin
                    g_d     = arb_g;
                    wc_d    = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (load) begin
                    wc_d = wc_q + WW'(1);
                    if (last_row) begin
                        served_d = served_after;
                        ptr_d    = (g_q == GMAX) ? '0 : g_q + GW'(1);
                        state_d  = ARB;
                    end
                end
            end
            FLUSH: begin
                if (!out_valid_q || out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            served_d    = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            g_q         <= '0;
            wc_q        <= '0;
            served_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef SYSTOLA_DRAIN_TAG_EN
            out_col_q   <= '0;
            out_row_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            g_q         <= g_d;
            wc_q        <= wc_d;
            served_q    <= served_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef SYSTOLA_DRAIN_TAG_EN
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FLUSH) && (!out_valid_q || out_ready) && !abort;
`ifdef SYSTOLA_DRAIN_TAG_EN
    assign out_col   = out_col_q;
    assign out_row   = out_row_q;
`endif

endmodule

// File: doc/col_drain_arbiter.md
COL_DRAIN_ARBITER -- requirements
Module: col_drain_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- COLS, 8, number of column output controllers sharing the drain port
- ROWS, 8, result words per column per drain
- OUTWIDTH, 32, result word width
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin one full drain of all columns; sampled in IDLE only
- abort  in  1  synchronous cancel of the drain in progress
- col_rvalid  in  [COLS]  per-column result available
- col_r  in  [COLS][OUTWIDTH]  per-column result word
- col_read  out  [COLS]  one-hot pop strobe to granted column
- out_data  out  OUTWIDTH  registered drained word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts word when out_valid && out_ready
- out_last  out  1  qualifies the final word (COLS*ROWS-th) of a drain
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at drain completion

Function
REQ-003 FSM states SHALL be IDLE, ARB, BURST, FLUSH.
REQ-004 IDLE: start=1 -> ARB; clear served mask; round-robin pointer ptr=0; start outside IDLE SHALL be ignored.
REQ-005 ARB: grant g = first column at or after ptr (mod COLS) with col_rvalid=1 and served=0 -> BURST, word count wc=0; all served -> FLUSH; unserved but none valid -> stay ARB.
REQ-006 BURST: load = col_rvalid[g] && (!out_valid || out_ready); col_read[g] SHALL equal load combinationally, all other col_read bits 0.
REQ-007 On load, out_data SHALL take col_r[g] and out_valid SHALL be 1 next cycle (latency 1 from col_read).
REQ-008 Accept and load in the same cycle SHALL replace the word with no bubble; accept without load SHALL clear out_valid.
REQ-009 out_valid=1 with out_ready=0 SHALL hold out_data, out_last stable.
REQ-010 col_rvalid[g] dropping mid-burst SHALL hold the grant and wc; no re-arbitration until ROWS words taken.
REQ-011 The ROWS-th load SHALL set served[g], ptr=(g+1) mod COLS, -> ARB; wc width $clog2(ROWS+1), wrap impossible.
REQ-012 out_last SHALL be 1 exactly with the word loaded when served would become all-ones.
REQ-013 FLUSH: when out_valid=0 or out_ready=1, pulse done for one cycle -> IDLE.
REQ-014 abort=1 in any state SHALL force IDLE next cycle, clear out_valid, out_last, served; col_read SHALL be 0 in that cycle; abort has priority over start and load.
REQ-015 Any col_read with no corresponding col_rvalid SHALL never occur.

Reset
REQ-016 rst=1 SHALL asynchronously force IDLE, ptr=0, wc=0, served=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, col_read=0.
REQ-017 rst mid-drain SHALL discard the drain; no done pulse on release.

Configuration
REQ-018 Macro SYSTOLA_DRAIN_TAG_EN defined: add outputs out_col [$clog2(COLS)] and out_row [$clog2(ROWS)], registered with out_data, giving g and wc of each word; reset 0.
REQ-019 Macro undefined: those ports and registers SHALL not exist; all other behaviour identical.

Verification
REQ-020 COLS=ROWS=8, all col_rvalid=1, out_ready=1, start -> 64 contiguous words, col 0..7 order, out_last on word 64, done 1 cycle after last accept.
REQ-021 Only col 3 valid at start, others valid 10 cycles later -> col 3 drained first, then 4,5,6,7,0,1,2.
REQ-022 out_ready toggling 1/0 each cycle -> no word lost or duplicated, col_read count per column exactly 8.
REQ-023 col_rvalid[g] low for 5 cycles after word 3 -> grant held, col_read 0, drain resumes at word 4 of same column.
REQ-024 abort at word 20 -> IDLE next cycle, out_valid 0, no done; new start drains all 64 words.
REQ-025 rst asserted mid-burst asynchronously -> all outputs 0 before next clk edge; with SYSTOLA_DRAIN_TAG_EN, out_col/out_row match source column/row for every word.
